// File: rtl/lu_acc.sv
// lu_acc: evaluates a per-point logic function over set-coverage bits and
// counts hits across a fixed-length frame, handing the count off on ack.
module lu_acc #(
   parameter int SET_NUM   = 3,
   parameter int FRAME_LEN = 64,
   parameter int CNT_W     = 7
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [2:0]         mode_i,
   input  logic               pt_valid_i,
   input  logic [SET_NUM-1:0] covered_i,
   output logic               hit_valid_o,
   output logic               hit_o,
   output logic               done_o,
   output logic [CNT_W-1:0]   count_o,
   input  logic               ack_i,
   output logic               busy_o
);
   localparam int PW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
   localparam logic [PW-1:0] LAST = PW'(FRAME_LEN - 1);

   if ((2 ** CNT_W) <= FRAME_LEN) begin : g_cnt_w_too_small
      $error("lu_acc: CNT_W cannot hold FRAME_LEN hits");
   end

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t           state_q, state_d;
   logic [2:0]       mode_q, mode_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PW-1:0]    pt_q, pt_d;
   logic             hit_q, hit_d, hit_valid_q, hit_valid_d;
   logic             done_q, done_d, busy_q, busy_d;
   logic             a, b, hit, acc;

   always_comb begin
      a   = covered_i[SET_NUM-1];
      b   = covered_i[SET_NUM-2];
      hit = mode_q == 3'd1 ? a :
            mode_q == 3'd2 ? a & b :
            mode_q == 3'd3 ? a ^ b :
            mode_q == 3'd4 ? (|covered_i) & ~(&covered_i) :
            mode_q == 3'd5 ? &covered_i :
            mode_q == 3'd6 ? $onehot(covered_i) : 1'b0;
      acc     = state_q == ACCUM && pt_valid_i;
      state_d = state_q;
      mode_d  = mode_q;
      count_d = count_q;
      pt_d    = pt_q;
      if (state_q == IDLE && start_i) begin
         state_d = ACCUM;
         mode_d  = mode_i;
         count_d = '0;
         pt_d    = '0;
      end
      if (acc) begin
         pt_d    = pt_q + 1'b1;
         // saturate instead of wrapping
         count_d = hit && count_q != '1 ? count_q + 1'b1 : count_q;
         if (pt_q == LAST) state_d = DONE;
      end
      if (state_q == DONE && ack_i) state_d = IDLE;
      hit_valid_d = acc;
      hit_d       = acc && hit;
      done_d      = state_d == DONE;
      busy_d      = state_d == ACCUM;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mode_q      <= '0;
         count_q     <= '0;
         pt_q        <= '0;
         hit_q       <= 1'b0;
         hit_valid_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         count_q     <= count_d;
         pt_q        <= pt_d;
         hit_q       <= hit_d;
         hit_valid_q <= hit_valid_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   assign hit_o       = hit_q;
   assign hit_valid_o = hit_valid_q;
   assign done_o      = done_q;
   assign busy_o      = busy_q;
   assign count_o     = count_q;
endmodule
